// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and lane constants for the game sequencer
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    PLAY  = 3'd2,
    DRAIN = 3'd3,
    SWAP  = 3'd4,
    OVER  = 3'd5
  } seq_state_t;

  localparam int NUM_LANES = 5;
  localparam int LANE_G    = 0;
  localparam int LANE_R    = 1;
  localparam int LANE_Y    = 2;
  localparam int LANE_B    = 3;
  localparam int LANE_O    = 4;

  function automatic logic is_running(input seq_state_t s);
    return (s == COUNT) || (s == PLAY) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/spawn_arbiter.sv
// rtl/spawn_arbiter.sv - round-robin lane grant limited by the on-screen note quota
module spawn_arbiter
  import game_pkg::*;
#(
  parameter int MAX_ACTIVE = 3
) (
  input  logic [4:0] cand,
  input  logic [4:0] busy,
  input  logic [2:0] rr_ptr,
  output logic [4:0] grant,
  output logic [2:0] next_ptr
);

  localparam logic [2:0] MAX_A = 3'(MAX_ACTIVE);

  logic [2:0] w_busy_cnt;
  logic [2:0] w_quota;
  logic [2:0] w_taken;
  logic [2:0] w_last;
  logic [2:0] w_lane;
  logic [3:0] w_sum;
  logic       w_any;

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_busy_cnt = w_busy_cnt + {2'b00, busy[i]};
    end
    w_quota = (w_busy_cnt >= MAX_A) ? 3'd0 : (MAX_A - w_busy_cnt);

    grant   = '0;
    w_taken = '0;
    w_last  = '0;
    w_any   = 1'b0;
    w_sum   = '0;
    w_lane  = '0;
    // Scan lanes starting at rr_ptr, wrapping past orange back to green.
    for (int i = 0; i < NUM_LANES; i++) begin
      w_sum  = {1'b0, rr_ptr} + 4'(i);
      w_lane = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
      if (cand[w_lane] && (w_taken < w_quota)) begin
        grant[w_lane] = 1'b1;
        w_taken       = w_taken + 3'd1;
        w_last        = w_lane;
        w_any         = 1'b1;
      end
    end

    if (!w_any) begin
      next_ptr = rr_ptr;
    end else if (w_last == 3'd4) begin
      next_ptr = 3'd0;
    end else begin
      next_ptr = w_last + 3'd1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round/turn controller and spawn pulse generator for the note highway
module game_sequencer
  import game_pkg::*;
#(
  parameter logic [31:0] BEAT_DIV        = 32'd1562500,
  parameter int          COUNTDOWN_BEATS = 4,
  parameter int          TURN_BEATS      = 64,
  parameter int          MAX_ACTIVE      = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [4:0] lane_req,
  input  logic [4:0] lane_busy,
  input  logic       mus_done,
  output logic [4:0] spawn,
  output logic       player_flag,
  output logic       score_en,
  output logic [3:0] countdown,
  output logic       beat_tick,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [31:0] DIV_LAST  = BEAT_DIV - 32'd1;
  localparam logic [3:0]  CD_INIT   = 4'(COUNTDOWN_BEATS);
  localparam logic [7:0]  TURN_INIT = 8'(TURN_BEATS);

  seq_state_t  r_state,   w_state_nxt;
  logic [31:0] r_div,     w_div_nxt;
  logic [3:0]  r_cd,      w_cd_nxt;
  logic [7:0]  r_turn,    w_turn_nxt;
  logic [2:0]  r_ptr,     w_ptr_nxt;
  logic        r_pf,      w_pf_nxt;
  logic        r_done,    w_done_nxt;
  logic [4:0]  r_spawn,   w_spawn_nxt;
  logic        r_tick,    w_tick_nxt;
  logic        r_score,   w_score_nxt;
  logic        r_over,    w_over_nxt;
  logic        r_start_d;

  logic [31:0] w_div_run;
  logic        w_start_rise;
  logic        w_done_eff;
  logic [4:0]  w_cand;
  logic [4:0]  w_grant;
  logic [2:0]  w_next_ptr;

  assign w_cand = lane_req & ~lane_busy;

  spawn_arbiter #(
    .MAX_ACTIVE(MAX_ACTIVE)
  ) u_arb (
    .cand    (w_cand),
    .busy    (lane_busy),
    .rr_ptr  (r_ptr),
    .grant   (w_grant),
    .next_ptr(w_next_ptr)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_cd      <= '0;
      r_turn    <= '0;
      r_ptr     <= '0;
      r_pf      <= 1'b0;
      r_done    <= 1'b0;
      r_spawn   <= '0;
      r_tick    <= 1'b0;
      r_score   <= 1'b0;
      r_over    <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_cd      <= w_cd_nxt;
      r_turn    <= w_turn_nxt;
      r_ptr     <= w_ptr_nxt;
      r_pf      <= w_pf_nxt;
      r_done    <= w_done_nxt;
      r_spawn   <= w_spawn_nxt;
      r_tick    <= w_tick_nxt;
      r_score   <= w_score_nxt;
      r_over    <= w_over_nxt;
      r_start_d <= start;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_cd_nxt     = r_cd;
    w_turn_nxt   = r_turn;
    w_ptr_nxt    = r_ptr;
    w_pf_nxt     = r_pf;
    w_done_nxt   = r_done;
    w_spawn_nxt  = '0;
    w_start_rise = start & ~r_start_d;
    w_done_eff   = r_done | mus_done;
    w_div_run    = (r_div == DIV_LAST) ? 32'd0 : (r_div + 32'd1);

    case (r_state)
      IDLE, OVER: begin
        if (w_start_rise) begin
          w_state_nxt = COUNT;
          w_div_nxt   = '0;
          w_cd_nxt    = CD_INIT;
          w_pf_nxt    = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      COUNT: begin
        w_div_nxt = w_div_run;
        if (r_tick) begin
          if (r_cd == 4'd1) begin
            w_state_nxt = PLAY;
            w_cd_nxt    = 4'd0;
            w_turn_nxt  = TURN_INIT;
          end else begin
            w_cd_nxt = r_cd - 4'd1;
          end
        end
      end
      PLAY: begin
        w_div_nxt = w_div_run;
        // A song end always wins over a grant on the same beat.
        if (mus_done) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = DRAIN;
        end else if (r_tick) begin
          w_spawn_nxt = w_grant;
          w_ptr_nxt   = w_next_ptr;
          w_turn_nxt  = r_turn - 8'd1;
          if (r_turn == 8'd1) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_div_nxt  = w_div_run;
        w_done_nxt = w_done_eff;
        if (lane_busy == 5'd0) begin
          if (!r_pf && !w_done_eff) begin
            w_state_nxt = SWAP;
            w_pf_nxt    = 1'b1;
            w_cd_nxt    = CD_INIT;
          end else begin
            w_state_nxt = OVER;
          end
        end
      end
      SWAP: begin
        w_state_nxt = COUNT;
        w_div_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Registered strobe lines up exactly with the cycle the divider sits at its last count.
    w_tick_nxt  = is_running(w_state_nxt) && (w_div_nxt == DIV_LAST);
    w_score_nxt = (w_state_nxt == PLAY) || (w_state_nxt == DRAIN);
    w_over_nxt  = (w_state_nxt == OVER);
  end

  assign spawn       = r_spawn;
  assign player_flag = r_pf;
  assign score_en    = r_score;
  assign countdown   = r_cd;
  assign beat_tick   = r_tick;
  assign game_over   = r_over;
  assign state       = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer against a phase model
module tb_game_sequencer;

  localparam int BD = 4;
  localparam int CB = 2;
  localparam int TB = 3;
  localparam int MA = 2;

  localparam int P_IDLE  = 0;
  localparam int P_COUNT = 1;
  localparam int P_PLAY  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_SWAP  = 4;
  localparam int P_OVER  = 5;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [4:0] lane_req;
  logic [4:0] lane_busy;
  logic       mus_done;
  logic [4:0] spawn;
  logic       player_flag;
  logic       score_en;
  logic [3:0] countdown;
  logic       beat_tick;
  logic       game_over;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  game_sequencer #(
    .BEAT_DIV       (32'(BD)),
    .COUNTDOWN_BEATS(CB),
    .TURN_BEATS     (TB),
    .MAX_ACTIVE     (MA)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .lane_req   (lane_req),
    .lane_busy  (lane_busy),
    .mus_done   (mus_done),
    .spawn      (spawn),
    .player_flag(player_flag),
    .score_en   (score_en),
    .countdown  (countdown),
    .beat_tick  (beat_tick),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 Clk = ~Clk;

  // Reference model: game phase, beat position within the current phase run, counters.
  int         m_ph, m_div, m_cd, m_turn, m_ptr;
  bit         m_pf, m_done, m_sprev, m_tick, m_rise;
  logic [4:0] m_spawn;
  logic [4:0] m_g;
  int         m_np;

  function automatic bit running(input int ph);
    return (ph == P_COUNT) || (ph == P_PLAY) || (ph == P_DRAIN);
  endfunction

  function automatic void arbitrate(input logic [4:0] req, input logic [4:0] busy, input int ptr,
                                    output logic [4:0] g, output int np);
    int q;
    int lane;
    q  = MA - $countones(busy);
    if (q < 0) q = 0;
    g  = '0;
    np = ptr;
    for (int k = 0; k < 5; k++) begin
      lane = (ptr + k) % 5;
      if (q > 0 && req[lane] && !busy[lane]) begin
        g[lane] = 1'b1;
        q       = q - 1;
        np      = (lane + 1) % 5;
      end
    end
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_ph = P_IDLE; m_div = 0; m_cd = 0; m_turn = 0; m_ptr = 0;
      m_pf = 0; m_done = 0; m_sprev = 0; m_spawn = '0;
    end else begin
      m_tick  = running(m_ph) && (m_div == BD - 1);
      m_rise  = start && !m_sprev;
      m_sprev = start;
      m_spawn = '0;
      if (running(m_ph)) m_div = (m_div + 1) % BD;
      case (m_ph)
        P_IDLE, P_OVER: if (m_rise) begin
          m_ph = P_COUNT; m_div = 0; m_cd = CB; m_pf = 0; m_done = 0;
        end
        P_COUNT: if (m_tick) begin
          if (m_cd == 1) begin m_ph = P_PLAY; m_cd = 0; m_turn = TB; end
          else m_cd = m_cd - 1;
        end
        P_PLAY: begin
          if (mus_done) begin
            m_done = 1; m_ph = P_DRAIN;
          end else if (m_tick) begin
            arbitrate(lane_req, lane_busy, m_ptr, m_g, m_np);
            m_spawn = m_g;
            m_ptr   = m_np;
            m_turn  = m_turn - 1;
            if (m_turn == 0) m_ph = P_DRAIN;
          end
        end
        P_DRAIN: begin
          m_done = m_done || mus_done;
          if (lane_busy == 5'd0) begin
            if (!m_pf && !m_done) begin m_ph = P_SWAP; m_pf = 1; m_cd = CB; end
            else m_ph = P_OVER;
          end
        end
        P_SWAP: begin m_ph = P_COUNT; m_div = 0; end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [15:0] act, exp;
    logic        e_tick;
    e_tick = running(m_ph) && (m_div == BD - 1);
    act = {state, player_flag, score_en, countdown, beat_tick, game_over, spawn};
    exp = {3'(m_ph), m_pf, (m_ph == P_PLAY) || (m_ph == P_DRAIN), 4'(m_cd), e_tick,
           (m_ph == P_OVER), m_spawn};
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL cycle t=%0t actual st=%0d pf=%0b se=%0b cd=%0d bt=%0b go=%0b sp=%b required st=%0d pf=%0b se=%0b cd=%0d bt=%0b go=%0b sp=%b",
               $time, act[15:13], act[12], act[11], act[10:7], act[6], act[5], act[4:0],
               exp[15:13], exp[12], exp[11], exp[10:7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    compare_all();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_tick();
    for (int n = 0; n < 40 && !beat_tick; n++) step();
    chk("tick_wait", 16'(beat_tick), 16'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    for (int n = 0; n < 60 && state != s; n++) step();
    chk(name, 16'(state), 16'(s));
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; lane_req = '0; lane_busy = '0; mus_done = 1'b0;
    step(); step();
    Reset = 1'b0;
    step();
    chk("reset_outputs", {state, player_flag, score_en, countdown, beat_tick, game_over, spawn}, 16'd0);

    // Turn 1: countdown and first spawns.
    pulse_start();
    chk("start_state", 16'(state), 16'd1);
    chk("start_cd", 16'(countdown), 16'd2);
    lane_req = 5'b11111;
    wait_tick();
    chk("cd_at_tick1", 16'(countdown), 16'd2);
    step();
    chk("cd_after_tick1", 16'(countdown), 16'd1);
    wait_tick();
    step();
    chk("play_entry", {state, player_flag, score_en, countdown}, {3'd2, 1'b0, 1'b1, 4'd0, 7'd0} >> 7);
    wait_tick();
    step();
    chk("spawn_first", 16'(spawn), 16'b00011);
    lane_busy = 5'b00011;
    step();
    chk("spawn_width", 16'(spawn), 16'd0);
    wait_tick();
    step();
    chk("spawn_quota0", 16'(spawn), 16'd0);
    lane_busy = 5'b00001; lane_req = 5'b10101;
    wait_tick();
    step();
    chk("turn_end_spawn", 16'(spawn), 16'b00100);
    chk("turn_end_drain", 16'(state), 16'd3);
    lane_busy = 5'b00100;
    for (int i = 0; i < 10; i++) step();
    chk("drain_hold", 16'(state), 16'd3);
    lane_busy = 5'b00000;
    step();
    chk("swap_state", {15'd0, state == 3'd4}, 16'd1);
    chk("swap_pf", 16'(player_flag), 16'd1);
    step();
    chk("swap_to_count", {state, countdown}, {9'd0, 3'd1, 4'd2});

    // Turn 2: pointer sits at 3, quota 1.
    lane_busy = 5'b00001; lane_req = 5'b10101;
    wait_state(3'd2, "turn2_play");
    wait_tick();
    step();
    chk("spawn_rr_wrap", 16'(spawn), 16'b10000);
    lane_busy = '0; lane_req = '0;
    wait_state(3'd5, "turn2_over");
    chk("over_flags", {game_over, player_flag}, 16'b11);

    // Song end on a grant beat: suppressed grant, straight to OVER.
    pulse_start();
    chk("restart_pf", 16'(player_flag), 16'd0);
    wait_state(3'd2, "mus_play");
    lane_req = 5'b11111;
    wait_tick();
    mus_done = 1'b1;
    step();
    mus_done = 1'b0;
    chk("mus_no_spawn", 16'(spawn), 16'd0);
    chk("mus_drain", 16'(state), 16'd3);
    step();
    chk("mus_over", {state, player_flag}, {12'd0, 3'd5, 1'b0});

    // Asynchronous reset mid-PLAY, then start ignored during PLAY.
    pulse_start();
    wait_state(3'd2, "rst_play");
    wait_tick();
    #2 Reset = 1'b1;
    #1 chk("async_reset", {state, player_flag, score_en, countdown, beat_tick, game_over, spawn}, 16'd0);
    step(); step();
    Reset = 1'b0;
    step();
    chk("after_reset_idle", 16'(state), 16'd0);
    pulse_start();
    wait_state(3'd2, "rst_replay");
    pulse_start();
    step();
    chk("start_ignored", 16'(state), 16'd2);

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 2500; c++) begin
      lane_req  = 5'($urandom);
      lane_busy = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      mus_done  = ($urandom_range(0, 79) == 0);
      start     = ($urandom_range(0, 15) == 0);
      Reset     = ($urandom_range(0, 999) == 0);
      step();
    end
    Reset = 1'b0; start = 1'b0; mus_done = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
